// File: rtl/sram_pkg.sv
// Shared defaults for the 1RW/1R SRAM model and its read pipeline.
package sram_pkg;

    localparam int unsigned DefaultDataWidth   = 32;
    localparam int unsigned DefaultAddrWidth   = 8;
    localparam int unsigned DefaultReadLatency = 1;
    localparam int unsigned ByteWidth          = 8;

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data pipeline: READ_LATENCY stages of data + valid, data held when no valid arrives.
module sram_rd_pipe #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0]   data_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   data_d [READ_LATENCY];
    logic [READ_LATENCY-1:0] valid_q;
    logic [READ_LATENCY-1:0] valid_d;

    // Each stage only loads on a valid beat, so the last stage keeps the last read value.
    always_comb begin
        valid_d    = '0;
        valid_d[0] = valid_i;
        data_d[0]  = valid_i ? data_i : data_q[0];
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q[READ_LATENCY-1];
    assign data_o  = data_q[READ_LATENCY-1];

endmodule

// File: rtl/sram_1rw1r_param.sv
// Single-clock SRAM with one read/write port (byte mask) and one read-only port.
module sram_1rw1r_param
    import sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DefaultDataWidth,
    parameter int unsigned ADDR_WIDTH   = DefaultAddrWidth,
    parameter int unsigned READ_LATENCY = DefaultReadLatency,
    localparam int unsigned NUM_WMASKS  = DATA_WIDTH / ByteWidth,
    localparam int unsigned RAM_DEPTH   = 2 ** ADDR_WIDTH
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  dout0_valid,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dout1_valid
);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic mem_we;
    logic rd0_req;
    logic rd1_req;

    always_comb begin
        mem_we  = !rst0 && !csb0 && !web0;
        rd0_req = !csb0 && web0;
        rd1_req = !csb1;
    end

    // Array is deliberately not reset; reads sample the array before this edge's write lands.
    always_ff @(posedge clk0) begin
        if (mem_we) begin
            for (int b = 0; b < int'(NUM_WMASKS); b++) begin
                if (wmask0[b]) begin
                    mem[addr0][b*ByteWidth +: ByteWidth] <= din0[b*ByteWidth +: ByteWidth];
                end
            end
        end
    end

    sram_rd_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_rd_pipe0 (
        .clk_i  (clk0),
        .rst_i  (rst0),
        .valid_i(rd0_req),
        .data_i (mem[addr0]),
        .valid_o(dout0_valid),
        .data_o (dout0)
    );

    sram_rd_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_rd_pipe1 (
        .clk_i  (clk0),
        .rst_i  (rst0),
        .valid_i(rd1_req),
        .data_i (mem[addr1]),
        .valid_o(dout1_valid),
        .data_o (dout1)
    );

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Directed bench for sram_1rw1r_param at READ_LATENCY=3.
module tb_sram_1rw1r_param;

    localparam int L = 3;

    logic        clk0;
    logic        rst0;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [7:0]  addr0;
    logic [31:0] din0;
    logic [31:0] dout0;
    logic        dout0_valid;
    logic        csb1;
    logic [7:0]  addr1;
    logic [31:0] dout1;
    logic        dout1_valid;

    int n_tests;
    int n_fail;

    sram_1rw1r_param #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (8),
        .READ_LATENCY(L)
    ) dut (
        .clk0       (clk0),
        .rst0       (rst0),
        .csb0       (csb0),
        .web0       (web0),
        .wmask0     (wmask0),
        .addr0      (addr0),
        .din0       (din0),
        .dout0      (dout0),
        .dout0_valid(dout0_valid),
        .csb1       (csb1),
        .addr1      (addr1),
        .dout1      (dout1),
        .dout1_valid(dout1_valid)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic idle();
        csb0   = 1'b1;
        web0   = 1'b1;
        wmask0 = 4'h0;
        csb1   = 1'b1;
    endtask

    task automatic write0(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        csb0   = 1'b0;
        web0   = 1'b0;
        addr0  = a;
        din0   = d;
        wmask0 = m;
        tick();
        idle();
    endtask

    // Issue reads on the enabled ports, then expect valid exactly on the L-th edge.
    task automatic read_check(input string tag, input bit en0, input logic [7:0] a0,
                              input logic [31:0] e0, input bit en1, input logic [7:0] a1,
                              input logic [31:0] e1);
        csb0  = !en0;
        web0  = 1'b1;
        addr0 = a0;
        csb1  = !en1;
        addr1 = a1;
        tick();
        idle();
        for (int t = 1; t <= L; t++) begin
            if (t < L) begin
                check_eq({tag, "_v0_early"}, {31'd0, dout0_valid}, 32'd0);
                check_eq({tag, "_v1_early"}, {31'd0, dout1_valid}, 32'd0);
            end else begin
                check_eq({tag, "_v0"}, {31'd0, dout0_valid}, {31'd0, en0});
                check_eq({tag, "_v1"}, {31'd0, dout1_valid}, {31'd0, en1});
                if (en0) check_eq({tag, "_d0"}, dout0, e0);
                if (en1) check_eq({tag, "_d1"}, dout1, e1);
            end
            if (t < L) tick();
        end
        tick();
        check_eq({tag, "_v0_after"}, {31'd0, dout0_valid}, 32'd0);
        check_eq({tag, "_v1_after"}, {31'd0, dout1_valid}, 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        addr0   = 8'h00;
        addr1   = 8'h00;
        din0    = 32'h0;
        idle();
        rst0 = 1'b1;
        tick();
        tick();
        check_eq("rst_dout0", dout0, 32'h0);
        check_eq("rst_dout1", dout1, 32'h0);
        check_eq("rst_v0", {31'd0, dout0_valid}, 32'd0);
        check_eq("rst_v1", {31'd0, dout1_valid}, 32'd0);
        rst0 = 1'b0;

        // Full write then port 0 read; the write itself must not raise dout0_valid.
        write0(8'h10, 32'hDEADBEEF, 4'hF);
        read_check("full_wr", 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 8'h00, 32'h0);
        check_eq("hold_d0", dout0, 32'hDEADBEEF);

        write0(8'h10, 32'h000000AA, 4'h1);
        read_check("byte0_wr", 1'b0, 8'h00, 32'h0, 1'b1, 8'h10, 32'hDEADBEAA);

        write0(8'h10, 32'hFFFFFFFF, 4'h0);
        write0(8'h10, 32'h11223344, 4'hA);
        read_check("mask_a", 1'b1, 8'h10, 32'h11AD33AA, 1'b1, 8'h10, 32'h11AD33AA);

        // Same-cycle write/read collision: port 1 sees the old word.
        write0(8'h20, 32'h00000000, 4'hF);
        csb0 = 1'b0; web0 = 1'b0; addr0 = 8'h20; din0 = 32'h12345678; wmask0 = 4'hF;
        csb1 = 1'b0; addr1 = 8'h20;
        tick();
        csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h20; wmask0 = 4'h0;
        csb1 = 1'b0; addr1 = 8'h20;
        tick();
        idle();
        tick();
        check_eq("rbw_v1", {31'd0, dout1_valid}, 32'd1);
        check_eq("rbw_d1", dout1, 32'h00000000);
        check_eq("rbw_v0", {31'd0, dout0_valid}, 32'd0);
        tick();
        check_eq("raw_v1", {31'd0, dout1_valid}, 32'd1);
        check_eq("raw_d1", dout1, 32'h12345678);
        check_eq("raw_v0", {31'd0, dout0_valid}, 32'd1);
        check_eq("raw_d0", dout0, 32'h12345678);
        tick();

        // Streaming reads: port 1 ascending, port 0 descending, every cycle.
        for (int i = 0; i < 8; i++) begin
            write0(8'(i), 32'hC0DE0000 | 32'(i), 4'hF);
        end
        for (int c = 0; c < 8 + L; c++) begin
            int k;
            if (c < 8) begin
                csb1  = 1'b0;
                addr1 = 8'(c);
                csb0  = 1'b0;
                web0  = 1'b1;
                addr0 = 8'(7 - c);
            end else begin
                idle();
            end
            tick();
            k = c + 1 - L;
            if (k >= 0 && k < 8) begin
                check_eq("strm_v1", {31'd0, dout1_valid}, 32'd1);
                check_eq("strm_d1", dout1, 32'hC0DE0000 | 32'(k));
                check_eq("strm_v0", {31'd0, dout0_valid}, 32'd1);
                check_eq("strm_d0", dout0, 32'hC0DE0000 | 32'(7 - k));
            end else begin
                check_eq("strm_v1_idle", {31'd0, dout1_valid}, 32'd0);
                check_eq("strm_v0_idle", {31'd0, dout0_valid}, 32'd0);
            end
        end

        // Deselected cycles: outputs hold the last read data.
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("idle_v0", {31'd0, dout0_valid}, 32'd0);
            check_eq("idle_v1", {31'd0, dout1_valid}, 32'd0);
            check_eq("idle_d0", dout0, 32'hC0DE0000);
            check_eq("idle_d1", dout1, 32'hC0DE0007);
        end

        // Reset with reads in flight plus a write and read presented during reset.
        csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h10;
        csb1 = 1'b0; addr1 = 8'h20;
        tick();
        rst0 = 1'b1;
        csb0 = 1'b0; web0 = 1'b0; addr0 = 8'h10; din0 = 32'hFFFFFFFF; wmask0 = 4'hF;
        csb1 = 1'b0; addr1 = 8'h10;
        #1;
        check_eq("arst_d0", dout0, 32'h0);
        check_eq("arst_d1", dout1, 32'h0);
        check_eq("arst_v0", {31'd0, dout0_valid}, 32'd0);
        check_eq("arst_v1", {31'd0, dout1_valid}, 32'd0);
        tick();
        check_eq("rst_hold_d0", dout0, 32'h0);
        check_eq("rst_hold_v0", {31'd0, dout0_valid}, 32'd0);
        rst0 = 1'b0;
        idle();
        read_check("post_rst", 1'b1, 8'h10, 32'h11AD33AA, 1'b1, 8'h20, 32'h12345678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_1rw1r_param.md
SRAM_1RW1R_PARAM -- requirements
Module: sram_1rw1r_param

Interface
REQ-001 Parameter DATA_WIDTH, default 32; word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 8; RAM_DEPTH = 2**ADDR_WIDTH words.
REQ-003 Parameter READ_LATENCY, default 1; legal range 1..4 cycles.
REQ-004 Derived constant NUM_WMASKS = DATA_WIDTH/8; one mask bit per byte.
REQ-005 clk0  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst0  input  1  reset, asynchronous, active-high.
REQ-007 csb0  input  1  port 0 chip select, active low.
REQ-008 web0  input  1  port 0 write enable, active low (0 = write, 1 = read).
REQ-009 wmask0  input  NUM_WMASKS  port 0 byte write mask, bit i enables din0[8i+7:8i].
REQ-010 addr0  input  ADDR_WIDTH  port 0 address.
REQ-011 din0  input  DATA_WIDTH  port 0 write data.
REQ-012 dout0  output  DATA_WIDTH  port 0 read data.
REQ-013 dout0_valid  output  1  dout0 carries fresh read data this cycle.
REQ-014 csb1  input  1  port 1 (read-only) chip select, active low.
REQ-015 addr1  input  ADDR_WIDTH  port 1 address.
REQ-016 dout1  output  DATA_WIDTH  port 1 read data.
REQ-017 dout1_valid  output  1  dout1 carries fresh read data this cycle.

Function
REQ-018 Port 0 write (csb0=0, web0=0) SHALL update the enabled bytes of mem[addr0] at the sampling edge; disabled bytes unchanged; wmask0=0 is a legal no-op write.
REQ-019 Port 0 read (csb0=0, web0=1) SHALL present mem[addr0] on dout0 with dout0_valid=1 exactly READ_LATENCY cycles after the sampling edge.
REQ-020 Port 1 read (csb1=0) SHALL present mem[addr1] on dout1 with dout1_valid=1 exactly READ_LATENCY cycles after the sampling edge.
REQ-021 Port 0 writes SHALL NOT assert dout0_valid.
REQ-022 dout0/dout1 SHALL hold their last value when the matching valid is 0.
REQ-023 Both ports SHALL accept a new request every cycle; read pipeline fully pipelined, no stalls.
REQ-024 Same-cycle port 0 write and port 1 read to the same address: port 1 SHALL return pre-write data (read-before-write).
REQ-025 A read issued the cycle after a write to the same address SHALL return the written data.
REQ-026 Address wrap not applicable: every addr value is in range; no out-of-range behaviour exists.
REQ-027 Memory array SHALL NOT be reset; contents before the first write are undefined (X in simulation).

Reset
REQ-028 rst0=1 SHALL immediately clear dout0, dout1 to 0 and dout0_valid, dout1_valid to 0.
REQ-029 rst0=1 SHALL flush all in-flight read pipeline stages; no valid SHALL appear for reads sampled before or during reset.
REQ-030 A write sampled on the same edge at which rst0 is high SHALL NOT modify memory.
REQ-031 First request SHALL be accepted on the first rising edge after rst0 deasserts.

Structure
REQ-032 Package sram_pkg SHALL hold default DATA_WIDTH, ADDR_WIDTH, READ_LATENCY and the byte-width constant 8.
REQ-033 Read pipeline SHALL be a sub-module sram_rd_pipe (parameters DATA_WIDTH, READ_LATENCY; data+valid shift chain with async reset), instantiated once per port.

Verification
REQ-034 Write 0xDEADBEEF to addr 0x10, wmask0=0xF; read port 0 addr 0x10 next cycle -> dout0=0xDEADBEEF, dout0_valid=1 after READ_LATENCY cycles.
REQ-035 Then write 0x000000AA to 0x10 with wmask0=0x1 -> port 1 read of 0x10 returns 0xDEADBEAA.
REQ-036 Same cycle: port 0 write 0x12345678 to 0x20 (old 0x0), port 1 read 0x20 -> dout1=0x00000000; next-cycle read returns 0x12345678.
REQ-037 Back-to-back port 1 reads of addr 0..7 with READ_LATENCY=3 -> eight consecutive valid cycles, data in address order, first at cycle 3.
REQ-038 Assert rst0 one cycle after issuing a read -> valids stay 0, douts 0, no stale valid after release.
REQ-039 Reads with csb0=csb1=1 for 5 cycles after a read -> valids 0, douts hold last read value.
